// File: rtl/matrix_op_issuer_pkg.sv
// Shared types and constants for the time-multiplexed 2x2 matrix multiply issuer.
// Operand words are opaque; the IEEE-754 constants exist for benches and bring-up.
package matrix_op_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE,
      MUL0_SEND,
      MUL0_WAIT,
      MUL1_SEND,
      MUL1_WAIT,
      ADD_SEND,
      ADD_WAIT,
      DONE
   } state_t;

   // Single-precision encodings of small integers and of the 2x2 products used in bring-up.
   localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
   localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
   localparam logic [31:0] FP_TWO   = 32'h4000_0000;
   localparam logic [31:0] FP_THREE = 32'h4040_0000;
   localparam logic [31:0] FP_FOUR  = 32'h4080_0000;
   localparam logic [31:0] FP_FIVE  = 32'h40A0_0000;
   localparam logic [31:0] FP_SIX   = 32'h40C0_0000;
   localparam logic [31:0] FP_SEVEN = 32'h40E0_0000;
   localparam logic [31:0] FP_EIGHT = 32'h4100_0000;
   localparam logic [31:0] FP_19    = 32'h4198_0000;
   localparam logic [31:0] FP_22    = 32'h41B0_0000;
   localparam logic [31:0] FP_43    = 32'h422C_0000;
   localparam logic [31:0] FP_50    = 32'h4248_0000;

endpackage

// File: rtl/matrix_op_issuer_if.sv
// stb/ack channel to one external arithmetic unit: two operands in, one result back.
// The issuer is the master; the arithmetic unit is the slave.
interface matrix_op_issuer_if
   import matrix_op_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             a_stb;
   logic             b_stb;
   logic             a_ack;
   logic             b_ack;
   logic [WIDTH-1:0] z;
   logic             z_stb;
   logic             z_ack;

   modport master (
      output a, b, a_stb, b_stb, z_ack,
      input  a_ack, b_ack, z, z_stb
   );

   modport slave (
      input  a, b, a_stb, b_stb, z_ack,
      output a_ack, b_ack, z, z_stb
   );

endinterface

// File: rtl/matrix_op_issuer_stb_source.sv
// One operand strobe: raised by load, cleared on the edge where it meets its ack.
module stb_source (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic ack,
   output logic stb
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         stb <= 1'b0;
      end else if (load) begin
         stb <= 1'b1;
      end else if (stb && ack) begin
         stb <= 1'b0;
      end
   end

endmodule

// File: rtl/matrix_op_issuer.sv
// Computes R = A x B for 2x2 matrices by sequencing one external multiplier and one
// external adder: per result element two products, then one sum, in order 00, 01, 10, 11.
module matrix_op_issuer
   import matrix_op_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   matrix_one_00,
   input  logic [WIDTH-1:0]   matrix_one_01,
   input  logic [WIDTH-1:0]   matrix_one_10,
   input  logic [WIDTH-1:0]   matrix_one_11,
   input  logic [WIDTH-1:0]   matrix_two_00,
   input  logic [WIDTH-1:0]   matrix_two_01,
   input  logic [WIDTH-1:0]   matrix_two_10,
   input  logic [WIDTH-1:0]   matrix_two_11,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result_00,
   output logic [WIDTH-1:0]   result_01,
   output logic [WIDTH-1:0]   result_10,
   output logic [WIDTH-1:0]   result_11,
   matrix_op_issuer_if.master mul,
   matrix_op_issuer_if.master add
);

   state_t           state;
   state_t           state_next;
   logic [1:0]       idx;
   logic [WIDTH-1:0] mat_a  [4];
   logic [WIDTH-1:0] mat_b  [4];
   logic [WIDTH-1:0] result [4];
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] p1;
   logic             mul_load;
   logic             add_load;
   logic             mul_sent;
   logic             add_sent;
   logic             mul_sel;

   // A send phase ends once each operand has either already transferred or transfers now.
   assign mul_sent = (!mul.a_stb || mul.a_ack) && (!mul.b_stb || mul.b_ack);
   assign add_sent = (!add.a_stb || add.a_ack) && (!add.b_stb || add.b_ack);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mul_load   = 1'b0;
      add_load   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = MUL0_SEND;
               mul_load   = 1'b1;
            end
         end
         MUL0_SEND: if (mul_sent) state_next = MUL0_WAIT;
         MUL0_WAIT: begin
            if (mul.z_stb) begin
               state_next = MUL1_SEND;
               mul_load   = 1'b1;
            end
         end
         MUL1_SEND: if (mul_sent) state_next = MUL1_WAIT;
         MUL1_WAIT: begin
            if (mul.z_stb) begin
               state_next = ADD_SEND;
               add_load   = 1'b1;
            end
         end
         ADD_SEND: if (add_sent) state_next = ADD_WAIT;
         ADD_WAIT: begin
            if (add.z_stb) begin
               if (idx == 2'd3) begin
                  state_next = DONE;
               end else begin
                  state_next = MUL0_SEND;
                  mul_load   = 1'b1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         idx <= 2'd0;
         p0  <= '0;
         p1  <= '0;
         for (int k = 0; k < 4; k++) begin
            mat_a[k]  <= '0;
            mat_b[k]  <= '0;
            result[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mat_a[0] <= matrix_one_00;
                  mat_a[1] <= matrix_one_01;
                  mat_a[2] <= matrix_one_10;
                  mat_a[3] <= matrix_one_11;
                  mat_b[0] <= matrix_two_00;
                  mat_b[1] <= matrix_two_01;
                  mat_b[2] <= matrix_two_10;
                  mat_b[3] <= matrix_two_11;
                  idx      <= 2'd0;
                  for (int k = 0; k < 4; k++) begin
                     result[k] <= '0;
                  end
               end
            end
            MUL0_WAIT: if (mul.z_stb) p0 <= mul.z;
            MUL1_WAIT: if (mul.z_stb) p1 <= mul.z;
            ADD_WAIT: begin
               if (add.z_stb) begin
                  result[idx] <= add.z;
                  if (idx != 2'd3) begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   stb_source u_mul_a_stb (.clock(clock), .reset(reset), .load(mul_load), .ack(mul.a_ack), .stb(mul.a_stb));
   stb_source u_mul_b_stb (.clock(clock), .reset(reset), .load(mul_load), .ack(mul.b_ack), .stb(mul.b_stb));
   stb_source u_add_a_stb (.clock(clock), .reset(reset), .load(add_load), .ack(add.a_ack), .stb(add.a_stb));
   stb_source u_add_b_stb (.clock(clock), .reset(reset), .load(add_load), .ack(add.b_ack), .stb(add.b_stb));

   // Element (i,j) multiplies A[i][k] by B[k][j]; k is 0 for the first product and 1 for the second.
   assign mul_sel   = (state == MUL1_SEND) || (state == MUL1_WAIT);
   assign mul.a     = mat_a[{idx[1], mul_sel}];
   assign mul.b     = mat_b[{mul_sel, idx[0]}];
   assign mul.z_ack = (state == MUL0_WAIT) || (state == MUL1_WAIT);
   assign add.a     = p0;
   assign add.b     = p1;
   assign add.z_ack = (state == ADD_WAIT);

   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);
   assign result_00 = result[0];
   assign result_01 = result[1];
   assign result_10 = result[2];
   assign result_11 = result[3];

endmodule

// File: doc/matrix_op_issuer.md
Name: matrix_op_issuer

Overview:
- Time-multiplexed 2x2 matrix multiply controller that computes R = A x B using one external FP multiplier and one external FP adder.
- It is the initiator side of the stb/ack operand protocol: it drives operands with strobes, waits for acks, then acks the unit's result strobe.
- It complements the fully parallel multiplier array and is used where area matters more than latency.
- Operands and results are opaque WIDTH-bit words; arithmetic happens entirely in the external units.

Parameters:
- WIDTH, 32, bit width of every operand, product and sum word.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- matrix_one_00/01/10/11  in  WIDTH each  matrix A, captured on the accepted start.
- matrix_two_00/01/10/11  in  WIDTH each  matrix B, captured on the accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when all four results are valid.
- result_00/01/10/11  out  WIDTH each  registered results.
- mul_a, mul_b  out  WIDTH  multiplier operands.
- mul_a_stb, mul_b_stb  out  1  operand strobes.
- mul_a_ack, mul_b_ack  in  1  operand acks from the multiplier.
- mul_z  in  WIDTH  product.
- mul_z_stb  in  1  product strobe from the multiplier.
- mul_z_ack  out  1  product ack to the multiplier.
- add_a, add_b  out  WIDTH  adder operands.
- add_a_stb, add_b_stb  out  1  operand strobes.
- add_a_ack, add_b_ack  in  1  operand acks from the adder.
- add_z  in  WIDTH  sum.
- add_z_stb  in  1  sum strobe from the adder.
- add_z_ack  out  1  sum ack to the adder.

Behaviour:
- Handshake rules
  - A transfer occurs on a rising edge where stb and ack are both 1.
  - While stb is high, the data word is held stable.
  - Each operand strobe (a and b) is tracked independently. It drops the cycle after its own transfer; the other strobe stays high until its own transfer.
  - z_ack is a Moore output: 1 throughout the matching Z_WAIT state, 0 elsewhere. The z word is captured on the transfer edge.
- Reset
  - On reset==0 at a clock edge: state=IDLE; all stb/ack outputs, busy, done and results = 0; captured operands cleared.
  - This applies mid-operation too. The external units share this reset, so no half-finished transfer survives.
- State machine
  - IDLE: start==1 latches A and B, sets idx=0, moves to MUL0_SEND.
  - MUL0_SEND: drive A[i][0] and B[0][j]. Move to MUL0_WAIT once both operands have transferred.
  - MUL0_WAIT: hold mul_z_ack=1. On transfer, p0 <= mul_z and move to MUL1_SEND.
  - MUL1_SEND and MUL1_WAIT: same sequence with A[i][1] and B[1][j]; the product goes to p1.
  - ADD_SEND: drive add_a=p0, add_b=p1.
  - ADD_WAIT: on transfer, result[idx] <= add_z.
  - Then: if idx==3 go to DONE; else idx++ and return to MUL0_SEND.
  - DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Ordering and indexing
  - idx is 2 bits: i = idx[1], j = idx[0].
  - Result order is 00, 01, 10, 11.
- Throughput and latency
  - A send state lasts at least 1 cycle; a wait state lasts at least 1 cycle.
  - With zero-wait external units, total latency from start acceptance to the done pulse is 24 cycles + 1 cycle for DONE.
  - Exactly 8 multiplier transactions and 4 adder transactions occur per operation.
- Results
  - Results update only as each element is written.
  - They hold their value after done until the next accepted start.
  - On the accepted start all four results clear to 0.
- Boundary conditions
  - start while busy or in DONE is ignored; it is not queued.
  - A z_stb arriving during a send state is not acked until the wait state.
  - An ack arriving while the matching stb is low has no effect.
  - Simultaneous a and b acks in the same cycle are legal and move to WAIT on the next cycle.

Decomposition:
- Package matrix_op_pkg holds:
  - state encoding constants: IDLE, MUL0_SEND, MUL0_WAIT, MUL1_SEND, MUL1_WAIT, ADD_SEND, ADD_WAIT, DONE;
  - the WIDTH default;
  - IEEE-754 test constants.
- One natural sub-module, stb_source, is a single operand strobe register.
  - Inputs: load (set stb), ack. Output: stb.
  - stb clears after a transfer.
  - Instantiated four times: mul a/b and add a/b.

Test Plan:
- Identity multiply, zero-wait behavioural units:
  - Stimulus: A = {3F800000, 40000000, 40400000, 40800000}, B = {3F800000, 0, 0, 3F800000}.
  - Required: results equal A, done pulses exactly once at cycle 25, busy low afterwards.
- General multiply:
  - Stimulus: same A, B = {40A00000, 40C00000, 40E00000, 41000000}.
  - Required: results = 41980000, 41B00000, 422C0000, 42480000.
  - Required: 8 multiplier and 4 adder transfers counted.
- Staggered handshakes:
  - Stimulus: mul_a_ack 3 cycles before mul_b_ack; mul_z_stb delayed 5 cycles.
  - Required: mul_b and its stb stable until transfer; mul_a_stb drops the cycle after its transfer; results same as the general multiply.
- start held high through the whole operation and pulsed again mid-operation:
  - Required: exactly one operation, one done pulse; a second operation begins only from IDLE.
- Reset mid-operation:
  - Stimulus: reset low during MUL1_WAIT of idx=2.
  - Required: next cycle all stb/ack=0, results=0, busy=0; a subsequent start completes correctly.
- Early z_stb during MUL0_SEND:
  - Required: mul_z_ack stays 0 until MUL0_WAIT; the product is captured there.
